// File: rtl/dmem_mmio_pkg.sv
// Shared address map, STATUS bit positions and UART TX state encoding for dmem_mmio.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dmem_mmio_pkg;

  // Address map: 0x00..RAM_TOP_ADDR is RAM; everything above the LED register is reserved.
  localparam logic [7:0] RAM_TOP_ADDR      = 8'hEF;
  localparam logic [7:0] MMIO_TX_DATA_ADDR = 8'hF0;
  localparam logic [7:0] MMIO_STATUS_ADDR  = 8'hF1;
  localparam logic [7:0] MMIO_LED_ADDR     = 8'hF2;

  localparam int RAM_WORDS = int'(RAM_TOP_ADDR) + 1;

  // STATUS register bit positions.
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_OVF_BIT   = 3;

  // UART TX frame states.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/dmem_mmio_uart_tx.sv
// UART 8N1 transmitter with TX queue (FIFO if DMEM_MMIO_TXFIFO_EN, else one holding register).
// Latency: a push into an empty queue with the FSM idle starts the start bit on the next edge.
// Backpressure: none; a push while full is dropped (push_drop) unless a pop frees a slot that edge.
// Ports: clock, nreset (sync, active-low); push_dat/push_vld push side; full, empty, busy status;
//        push_drop flags a rejected push; tx is the serial line (idles high).
module dmem_mmio_uart_tx
  import dmem_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic [7:0] push_dat,
  input  logic       push_vld,
  output logic       full,
  output logic       empty,
  output logic       push_drop,
  output logic       busy,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;

  logic       bit_end;
  logic       pop;
  logic       push_acc;
  logic [7:0] head_dat;

  assign bit_end = (cnt_q == CNT_LAST);
  // A new byte is taken either straight from idle or at the last cycle of a stop bit,
  // so back-to-back frames carry no idle gap.
  assign pop      = !empty && ((state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end));
  // A same-edge pop frees a slot for a push into a full queue; a push into an empty
  // queue is never visible to the pop on the same edge because pop uses the old empty.
  assign push_acc  = push_vld && (!full || pop);
  assign push_drop = push_vld && full && !pop;

`ifdef DMEM_MMIO_TXFIFO_EN
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full (only MSB differs) from empty (equal).
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == PTR_W'(FIFO_DEPTH));
  assign head_dat = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_acc) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_dat;
  end
`else
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] hold_dat_q, hold_dat_d;

  assign empty    = !hold_vld_q;
  assign full     = hold_vld_q;
  assign head_dat = hold_dat_q;

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    if (push_acc) begin
      hold_vld_d = 1'b1;
      hold_dat_d = push_dat;
    end else if (pop) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
    end
  end
`endif

  // Frame FSM: every non-idle state counts CLKS_PER_BIT cycles per bit period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (pop) begin
          state_d = TX_START;
          shift_d = head_dat;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (pop) begin
            state_d = TX_START;
            shift_d = head_dat;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign busy = (state_q != TX_IDLE);

  // The line is decoded from state so reset forces it high on the reset edge.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shift_q[0];
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: RAM plus TX_DATA / STATUS / LED registers, UART TX behind TX_DATA.
// Latency: reads are combinational from dmem_addr; writes commit on the rising edge.
// Backpressure: none; TX_DATA writes into a full queue are dropped and set sticky overflow.
// Ports: clock, nreset (sync, active-low); dmem_addr/dmem_wenable/dmem_wvalue from the CPU;
//        dmem_rvalue read data; uart_tx serial line; led register contents.
// Build option: DMEM_MMIO_TXFIFO_EN selects a FIFO_DEPTH-entry TX FIFO over a holding register.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic                  dmem_wenable,
  input  logic [DATA_WIDTH-1:0] dmem_wvalue,
  output logic [DATA_WIDTH-1:0] dmem_rvalue,
  output logic                  uart_tx,
  output logic [DATA_WIDTH-1:0] led
);

  logic is_ram, is_tx_data, is_status, is_led;

  assign is_ram     = (dmem_addr <= ADDR_WIDTH'(RAM_TOP_ADDR));
  assign is_tx_data = (dmem_addr == ADDR_WIDTH'(MMIO_TX_DATA_ADDR));
  assign is_status  = (dmem_addr == ADDR_WIDTH'(MMIO_STATUS_ADDR));
  assign is_led     = (dmem_addr == ADDR_WIDTH'(MMIO_LED_ADDR));

  // RAM has no reset: contents persist across nreset and are undefined after power-up.
  logic [DATA_WIDTH-1:0] ram_q [RAM_WORDS];

  always_ff @(posedge clock) begin
    if (dmem_wenable && is_ram) ram_q[dmem_addr] <= dmem_wvalue;
  end

  logic [DATA_WIDTH-1:0] led_q, led_d;
  logic                  ovf_q, ovf_d;

  logic tx_push, tx_full, tx_empty, tx_drop, tx_busy;

  assign tx_push = dmem_wenable && is_tx_data;

  always_comb begin
    led_d = led_q;
    ovf_d = ovf_q;
    if (dmem_wenable && is_led)    led_d = dmem_wvalue;
    if (dmem_wenable && is_status) ovf_d = 1'b0;
    else if (tx_drop)              ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      led_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      led_q <= led_d;
      ovf_q <= ovf_d;
    end
  end

  assign led = led_q;

  dmem_mmio_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_uart_tx (
    .clock    (clock),
    .nreset   (nreset),
    .push_dat (dmem_wvalue[7:0]),
    .push_vld (tx_push),
    .full     (tx_full),
    .empty    (tx_empty),
    .push_drop(tx_drop),
    .busy     (tx_busy),
    .tx       (uart_tx)
  );

  // Read mux; TX_DATA and reserved addresses read as zero.
  always_comb begin
    dmem_rvalue = '0;
    if (is_ram) begin
      dmem_rvalue = ram_q[dmem_addr];
    end else if (is_status) begin
      dmem_rvalue[STAT_BUSY_BIT]  = tx_busy;
      dmem_rvalue[STAT_FULL_BIT]  = tx_full;
      dmem_rvalue[STAT_EMPTY_BIT] = tx_empty;
      dmem_rvalue[STAT_OVF_BIT]   = ovf_q;
    end else if (is_led) begin
      dmem_rvalue = led_q;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  localparam int C = 4;
`ifdef DMEM_MMIO_TXFIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  localparam int FRAME = 10 * C;

  logic       clock = 1'b0;
  logic       nreset;
  logic [7:0] dmem_addr;
  logic       dmem_wenable;
  logic [7:0] dmem_wvalue;
  logic [7:0] dmem_rvalue;
  logic       uart_tx;
  logic [7:0] led;

  dmem_mmio #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .CLKS_PER_BIT(C), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .nreset(nreset), .dmem_addr(dmem_addr), .dmem_wenable(dmem_wenable),
    .dmem_wvalue(dmem_wvalue), .dmem_rvalue(dmem_rvalue), .uart_tx(uart_tx), .led(led)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Queue of pending bytes, plus "frame in flight" described by elapsed cycles t_m.
  logic [7:0] q[$];
  bit         busy_m = 0;
  int         t_m = 0;
  logic [7:0] sh_m = 0;
  bit         ovf_m = 0;
  logic [7:0] led_m = 0;
  logic [7:0] ram_m [0:255];
  bit         ram_known [0:255];

  function automatic logic model_tx();
    if (!busy_m) return 1'b1;
    if (t_m < C) return 1'b0;
    if (t_m < 9 * C) return sh_m[(t_m - C) / C];
    return 1'b1;
  endfunction

  function automatic logic [7:0] status_m();
    return {4'b0, ovf_m, q.size() == 0, q.size() == CAP, busy_m};
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a <= 8'hEF) return ram_m[a];
    if (a == 8'hF1) return status_m();
    if (a == 8'hF2) return led_m;
    return 8'h00;
  endfunction

  task automatic model_edge(input bit wen, input logic [7:0] a, input logic [7:0] d, input bit rn);
    bit fin, pop, push_ok;
    if (!rn) begin
      q.delete(); busy_m = 0; t_m = 0; ovf_m = 0; led_m = 0;
      return;
    end
    fin = busy_m && (t_m == FRAME - 1);
    pop = (q.size() > 0) && (!busy_m || fin);
    if (wen && a <= 8'hEF) begin ram_m[a] = d; ram_known[a] = 1; end
    if (wen && a == 8'hF2) led_m = d;
    if (wen && a == 8'hF1) ovf_m = 0;
    push_ok = (q.size() < CAP) || pop;
    if (wen && a == 8'hF0 && !push_ok) ovf_m = 1;
    if (pop) begin sh_m = q.pop_front(); busy_m = 1; t_m = 0; end
    else if (fin) begin busy_m = 0; t_m = 0; end
    else if (busy_m) t_m++;
    if (wen && a == 8'hF0 && push_ok) q.push_back(d);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%02h expected=0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_chk(input string name, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s wait bound expired at %0t", name, $time);
    end
  endtask

  logic [7:0] st_s;
  logic       tx_s;

  // One clock: drive inputs, take the edge, then sample STATUS/uart_tx/led on the falling edge.
  task automatic cyc(input bit wen, input logic [7:0] a, input logic [7:0] d, input bit rn);
    dmem_wenable = wen; dmem_addr = a; dmem_wvalue = d; nreset = rn;
    @(posedge clock);
    model_edge(wen, a, d, rn);
    @(negedge clock);
    dmem_wenable = 0; nreset = 1; dmem_addr = 8'hF1;
    #1;
    st_s = dmem_rvalue;
    tx_s = uart_tx;
    chk("status", st_s, status_m());
    chk("uart_tx", {7'b0, tx_s}, {7'b0, model_tx()});
    chk("led", led, led_m);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    dmem_wenable = 0; dmem_addr = a;
    #1;
    v = dmem_rvalue;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 8'h00, 1);
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((busy_m || q.size() > 0) && n < 2000) begin idle(1); n++; end
    bound_chk(name, n < 2000);
  endtask

  task automatic wait_t(input string name, input int target);
    int n = 0;
    while (!(busy_m && t_m == target) && n < 1000) begin idle(1); n++; end
    bound_chk(name, n < 1000);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         wen;
    logic [7:0] addr;
    logic [7:0] data;
    bit         do_chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] v;
  logic [7:0] frame_bits;
  int busy_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin ram_known[i] = 0; ram_m[i] = 0; end
    dmem_wenable = 0; dmem_addr = 0; dmem_wvalue = 0; nreset = 0;

    // reset state
    cyc(0, 8'h00, 8'h00, 0);
    chk("reset_status", st_s, 8'h04);
    chk("reset_uart", {7'b0, tx_s}, 8'h01);
    chk("reset_led", led, 8'h00);

    vecs = '{
      '{1, 8'h10, 8'h5A, 0, 8'h00},
      '{0, 8'h10, 8'h00, 1, 8'h5A},
      '{0, 8'hF5, 8'h00, 1, 8'h00},
      '{1, 8'hF5, 8'h77, 0, 8'h00},
      '{0, 8'h10, 8'h00, 1, 8'h5A},
      '{0, 8'hF0, 8'h00, 1, 8'h00},
      '{1, 8'hF2, 8'hA5, 0, 8'h00},
      '{0, 8'hF2, 8'h00, 1, 8'hA5},
      '{1, 8'h00, 8'h11, 0, 8'h00},
      '{1, 8'hEF, 8'h22, 0, 8'h00},
      '{0, 8'h00, 8'h00, 1, 8'h11},
      '{0, 8'hEF, 8'h00, 1, 8'h22},
      '{0, 8'hF3, 8'h00, 1, 8'h00},
      '{0, 8'hFF, 8'h00, 1, 8'h00},
      '{0, 8'hF1, 8'h00, 1, 8'h04}
    };
    foreach (vecs[i]) begin
      cyc(vecs[i].wen, vecs[i].addr, vecs[i].data, 1);
      if (vecs[i].do_chk) begin
        rd(vecs[i].addr, v);
        chk($sformatf("vec%0d_read", i), v, vecs[i].exp);
      end
    end
    chk("led_after_write", led, 8'hA5);

    // reset pulse: LED and STATUS return to reset values, RAM keeps its contents
    cyc(0, 8'h00, 8'h00, 0);
    chk("pulse_led", led, 8'h00);
    chk("pulse_status", st_s, 8'h04);
    rd(8'h10, v);
    chk("ram_survives_reset", v, 8'h5A);

    // single frame of 0x35: start, 1,0,1,0,1,1,0,0, stop
    frame_bits = 8'h35;
    cyc(1, 8'hF0, 8'h35, 1);
    chk("pre_start_uart", {7'b0, tx_s}, 8'h01);
    for (int k = 0; k < FRAME; k++) begin
      logic e;
      idle(1);
      if (k < C) e = 1'b0;
      else if (k < 9 * C) e = frame_bits[(k - C) / C];
      else e = 1'b1;
      chk($sformatf("frame_bit_k%0d", k), {7'b0, tx_s}, {7'b0, e});
      chk("frame_busy", {7'b0, st_s[0]}, 8'h01);
    end
    idle(1);
    chk("post_frame_status", st_s, 8'h04);
    chk("post_frame_uart", {7'b0, tx_s}, 8'h01);

    // fill queue, overflow, clear, back-to-back drain
    wait_drained("drain0");
    busy_cnt = 0;
    for (int i = 0; i < CAP + 2; i++) begin
      cyc(1, 8'hF0, 8'(8'h40 + i), 1);
      busy_cnt += st_s[0];
      if (i == CAP) chk("fill_busy_full", st_s, 8'h03);
      if (i == CAP + 1) chk("fill_overflow", st_s, 8'h0B);
    end
    cyc(1, 8'hF1, 8'hFF, 1);
    busy_cnt += st_s[0];
    chk("ovf_cleared", st_s, 8'h03);
    begin
      int n = 0;
      while (st_s[0] && n < 1000) begin idle(1); busy_cnt += st_s[0]; n++; end
      bound_chk("b2b_drain", n < 1000);
    end
    chk("b2b_busy_cycles", 8'(busy_cnt / C), 8'((CAP + 1) * FRAME / C));

    // push into a full queue on the edge a new frame pops it: accepted, no overflow
    wait_drained("drain1");
    for (int i = 0; i < CAP + 1; i++) cyc(1, 8'hF0, 8'(8'h60 + i), 1);
    chk("samepop_full", st_s, 8'h03);
    wait_t("samepop_wait", FRAME - 1);
    cyc(1, 8'hF0, 8'hC6, 1);
    chk("samepop_accept", st_s, 8'h03);
    wait_drained("drain2");

    // reset in the middle of data bit 3 with more bytes queued
    cyc(1, 8'hF0, 8'h96, 1);
    cyc(1, 8'hF0, 8'h69, 1);
    wait_t("midframe_wait", 4 * C + 1);
    cyc(0, 8'h00, 8'h00, 0);
    chk("midreset_uart", {7'b0, tx_s}, 8'h01);
    chk("midreset_status", st_s, 8'h04);
    cyc(1, 8'hF0, 8'hC3, 1);
    idle(1);
    chk("clean_start", {7'b0, tx_s}, 8'h00);
    wait_drained("drain3");

    // randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      int r;
      logic [7:0] a, d;
      a = 8'($urandom_range(0, 255));
      rd(a, v);
      if (a > 8'hEF || ram_known[a]) chk("rand_read", v, model_read(a));
      r = $urandom_range(0, 99);
      d = 8'($urandom);
      a = 8'($urandom_range(0, 255));
      if (r < 6) cyc(1, 8'hF0, d, 1);
      else if (r < 9) cyc(1, 8'hF1, d, 1);
      else if (r < 14) cyc(1, 8'hF2, d, 1);
      else if (r < 45) cyc(1, a, d, 1);
      else if (r < 46) cyc(0, 8'h00, 8'h00, 0);
      else cyc(0, a, d, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-memory stage directly downstream of the CPU's data-memory port. It consumes dmem_addr, dmem_wenable and dmem_wvalue, and returns dmem_rvalue combinationally in the same cycle.
- The address space holds a general RAM plus three memory-mapped registers: a UART transmit data register, a UART status register and an LED register.
- A sub-module, uart_tx, serialises queued bytes as 8N1 frames on uart_tx.

Parameters:
- DATA_WIDTH, 8, data word width; matches the CPU register width.
- ADDR_WIDTH, 8, data address width.
- CLKS_PER_BIT, 16, clock cycles per UART bit. Legal values are 2 or more.
- FIFO_DEPTH, 4, TX FIFO entries. Must be a power of 2; only used when the FIFO is compiled in.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- nreset  in  1  reset, synchronous, active-low.
- dmem_addr  in  ADDR_WIDTH  access address from the CPU.
- dmem_wenable  in  1  write strobe; when high the access is a write.
- dmem_wvalue  in  DATA_WIDTH  write data.
- dmem_rvalue  out  DATA_WIDTH  read data; combinational from dmem_addr.
- uart_tx  out  1  serial output; idles high.
- led  out  DATA_WIDTH  LED register contents.

Behaviour:
- Address map (constants live in the shared package):
  - 0x00-0xEF: RAM.
  - 0xF0: TX_DATA.
  - 0xF1: STATUS.
  - 0xF2: LED.
  - 0xF3-0xFF: reserved. Reads return 0; writes are ignored.
- Reads are asynchronous and have zero latency:
  - RAM address: returns the stored word.
  - TX_DATA: returns 0.
  - STATUS: returns {4'b0, overflow, fifo_empty, fifo_full, tx_busy}.
  - LED: returns the LED register.
- Writes commit on the rising edge when dmem_wenable=1:
  - RAM address: the word is written.
  - LED: led updates on that edge.
  - TX_DATA: pushes wvalue into the FIFO. If the FIFO is full, the byte is dropped and overflow is set (sticky).
  - STATUS: any value written clears overflow.
- Reset (nreset=0 at a rising edge), including mid-frame:
  - uart_tx=1, led=0, FIFO emptied, overflow=0, uart_tx FSM returns to IDLE.
  - RAM contents are unaffected and undefined after power-up.
- uart_tx FSM has four states: IDLE, START, DATA, STOP.
  - IDLE -> START on the first edge where the FIFO is non-empty. The FIFO is popped and the byte loaded into the shift register on that edge. uart_tx=0 from that edge on.
  - START lasts CLKS_PER_BIT cycles, then -> DATA.
  - DATA sends 8 bits, LSB first, CLKS_PER_BIT cycles each, tracked by a 3-bit index. After bit 7 -> STOP.
  - STOP drives uart_tx=1 for CLKS_PER_BIT cycles. At the end it goes to START with a pop if the FIFO is non-empty, otherwise to IDLE. Back-to-back frames therefore have no extra idle gap.
- tx_busy=1 in any state other than IDLE.
- Latency: a TX_DATA write at edge N gives a start bit beginning at edge N+1 if the FIFO was empty and the FSM was IDLE.
- Simultaneous push and pop on the same edge:
  - FIFO full: the pop frees a slot and the push is accepted; no overflow.
  - FIFO empty: the pushed byte cannot be popped until the next edge.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - full: pointers differ only in the MSB.
  - empty: pointers are equal.
- Writes when wenable is asserted while dmem_addr is reserved have no side effects.

Optional Feature:
- Macro: DMEM_MMIO_TXFIFO_EN.
- Defined: TX FIFO of FIFO_DEPTH entries, as described above.
- Undefined: single-entry holding register replaces the FIFO.
  - fifo_full = holding register valid.
  - fifo_empty = !valid.
  - A TX_DATA write while valid=1 is dropped and sets overflow, unless the FSM loads the holding register on that same edge (the same-edge push/pop rule above).
  - Timing is otherwise identical.

Decomposition:
- Shared package (config include), holding:
  - Address constants MMIO_TX_DATA_ADDR, MMIO_STATUS_ADDR, MMIO_LED_ADDR, RAM_TOP_ADDR.
  - STATUS bit-index constants.
  - uart_tx state encoding constants.
- Sub-module uart_tx, instantiated once. It contains the FSM, bit-period counter, shift register and the FIFO (or the holding register).
  - Push side: data, push, full.
  - Status outputs: busy, empty.
- The top level does address decode, RAM, LED, the overflow flag and the read mux.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- RAM round trip:
  - Write 0x5A to 0x10, then read 0x10 -> rvalue=0x5A combinationally.
  - Read 0xF5 -> 0x00.
  - Write to 0xF5, then read 0x10 -> still 0x5A.
- LED and reset:
  - Write 0xA5 to 0xF2 -> led=0xA5 from the next edge.
  - Pulse nreset for one edge -> led=0x00, STATUS=0x04.
- Single frame:
  - Write 0x35 to 0xF0 at edge N.
  - uart_tx is low for edges N+1..N+4, then data bits 1,0,1,0,1,1,0,0, each 4 cycles, then high for 4 cycles.
  - STATUS bit0=1 throughout the frame and 0 afterwards.
- FIFO fill and overflow:
  - Write 6 bytes to 0xF0 on consecutive cycles.
  - 1 is popped into the shifter and 4 are queued -> STATUS = busy|full.
  - The 6th write sets overflow -> STATUS=0x0B.
  - Write to 0xF1 -> overflow cleared.
  - Exactly 5 frames follow back to back with no idle gap.
- Reset mid-frame:
  - Assert nreset=0 during DATA bit 3 -> uart_tx=1 at that edge, FIFO empty, STATUS=0x04.
  - A new write after release produces a clean frame.
- Optional feature:
  - Without DMEM_MMIO_TXFIFO_EN: two writes while busy -> first held (full=1), second dropped with overflow=1.
  - A write on the same edge the FSM loads the holding register is accepted.
